// File: rtl/approx_add_pipe.sv
// Pipelined unsigned adder with a runtime-selectable exact or lower-part-OR (LOA) mode.
// The carry chain is split into STAGES equal segments. Each segment is registered, and every
// stage has valid/ready flow control.
// Optional feature macro: APPROX_ADD_STATS_EN adds delivered-beat error statistics. These are
// computed against an exact sum that travels down the pipe alongside each beat.
module approx_add_pipe #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned APPROX_LSB = 4,
  parameter int unsigned STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_mode
`ifdef APPROX_ADD_STATS_EN
  ,
  output logic [31:0]      stat_beats,
  output logic [31:0]      stat_err_cnt,
  output logic [WIDTH-1:0] stat_max_err,
  input  logic             stat_clr
`endif
);

  localparam int SegW = int'(WIDTH / STAGES);
  localparam int K    = int'(APPROX_LSB);

  // Per-stage state: segment sums accumulated so far, carry out, raw operands, mode
  logic [STAGES-1:0]            r_vld;
  logic [STAGES-1:0]            r_mode;
  logic [STAGES-1:0]            r_cy;
  logic [STAGES-1:0][WIDTH-1:0] r_a;
  logic [STAGES-1:0][WIDTH-1:0] r_b;
  logic [STAGES-1:0][WIDTH-1:0] r_sum;

  // Inputs seen by each stage (port side for stage 0, previous register otherwise)
  logic [STAGES-1:0]            w_src_vld;
  logic [STAGES-1:0]            w_src_mode;
  logic [STAGES-1:0]            w_src_cy;
  logic [STAGES-1:0][WIDTH-1:0] w_src_a;
  logic [STAGES-1:0][WIDTH-1:0] w_src_b;
  logic [STAGES-1:0][WIDTH-1:0] w_src_sum;

  logic [STAGES-1:0][WIDTH-1:0] w_nxt_sum;
  logic [STAGES-1:0]            w_nxt_cy;
  logic [STAGES-1:0]            w_free;

  // Operand and register bits outside a stage's live segment are intentionally unread
  logic w_unused;
  assign w_unused = ^{r_a, r_b};

  // Route each stage's source: ports into stage 0, stage s-1 registers into stage s
  always_comb begin
    w_src_vld  = '0;
    w_src_mode = '0;
    w_src_cy   = '0;
    w_src_a    = '0;
    w_src_b    = '0;
    w_src_sum  = '0;
    w_src_vld[0]  = in_valid;
    w_src_mode[0] = in_mode;
    w_src_a[0]    = in_a;
    w_src_b[0]    = in_b;
    for (int s = 1; s < STAGES; s++) begin
      w_src_vld[s]  = r_vld[s-1];
      w_src_mode[s] = r_mode[s-1];
      w_src_cy[s]   = r_cy[s-1];
      w_src_a[s]    = r_a[s-1];
      w_src_b[s]    = r_b[s-1];
      w_src_sum[s]  = r_sum[s-1];
    end
  end

  // Ripple each stage's segment; in approx mode bits below K are OR'd and the only carry
  // leaving the OR region is a[K-1]&b[K-1], injected at bit K whichever segment holds it
  always_comb begin
    w_nxt_sum = w_src_sum;
    w_nxt_cy  = '0;
    for (int s = 0; s < int'(STAGES); s++) begin
      logic c;
      logic va;
      logic vb;
      int   idx;
      c = w_src_cy[s];
      for (int i = 0; i < SegW; i++) begin
        idx = s * SegW + i;
        va  = w_src_a[s][idx];
        vb  = w_src_b[s][idx];
        if (w_src_mode[s] && (idx < K)) begin
          w_nxt_sum[s][idx] = va | vb;
          c = (idx == K - 1) ? (va & vb) : 1'b0;
        end else begin
          w_nxt_sum[s][idx] = va ^ vb ^ c;
          c = (va & vb) | (c & (va ^ vb));
        end
      end
      w_nxt_cy[s] = c;
    end
  end

  // A stage may load when it is empty or its contents move on this cycle
  always_comb begin
    w_free = '0;
    w_free[STAGES-1] = ~r_vld[STAGES-1] | out_ready;
    for (int s = int'(STAGES) - 2; s >= 0; s--) begin
      w_free[s] = ~r_vld[s] | w_free[s+1];
    end
  end

  assign in_ready = w_free[0];

  // Pipeline registers; data only moves when a valid beat arrives, so a held output stays put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_mode <= '0;
      r_cy   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
    end else begin
      for (int s = 0; s < int'(STAGES); s++) begin
        if (w_free[s]) begin
          r_vld[s] <= w_src_vld[s];
          if (w_src_vld[s]) begin
            r_mode[s] <= w_src_mode[s];
            r_cy[s]   <= w_nxt_cy[s];
            r_a[s]    <= w_src_a[s];
            r_b[s]    <= w_src_b[s];
            r_sum[s]  <= w_nxt_sum[s];
          end
        end
      end
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign out_sum   = {r_cy[STAGES-1], r_sum[STAGES-1]};
  assign out_mode  = r_mode[STAGES-1];

`ifdef APPROX_ADD_STATS_EN
  logic [STAGES-1:0][WIDTH:0] r_ex;
  logic [STAGES-1:0][WIDTH:0] w_src_ex;
  logic                       w_deliver;
  logic [WIDTH:0]             w_diff;
  logic [WIDTH-1:0]           w_err;

  // Exact reference sum enters with the beat and follows it stage by stage
  always_comb begin
    w_src_ex    = '0;
    w_src_ex[0] = {1'b0, in_a} + {1'b0, in_b};
    for (int s = 1; s < STAGES; s++) begin
      w_src_ex[s] = r_ex[s-1];
    end
  end

  // Exact-sum shadow registers, loaded under the same enables as the main path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= '0;
    end else begin
      for (int s = 0; s < int'(STAGES); s++) begin
        if (w_free[s] && w_src_vld[s]) begin
          r_ex[s] <= w_src_ex[s];
        end
      end
    end
  end

  assign w_deliver = out_valid & out_ready;
  // LOA error is at most 2^K <= 2^(WIDTH-1), so the low WIDTH bits hold it exactly
  assign w_diff    = (out_sum >= r_ex[STAGES-1]) ? (out_sum - r_ex[STAGES-1])
                                                 : (r_ex[STAGES-1] - out_sum);
  assign w_err     = w_diff[WIDTH-1:0];

  logic w_unused_diff;
  assign w_unused_diff = w_diff[WIDTH];

  // Statistics counters; clear wins over a same-cycle update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats   <= '0;
      stat_err_cnt <= '0;
      stat_max_err <= '0;
    end else if (stat_clr) begin
      stat_beats   <= '0;
      stat_err_cnt <= '0;
      stat_max_err <= '0;
    end else if (w_deliver) begin
      if (stat_beats != '1) stat_beats <= stat_beats + 32'd1;
      if ((w_err != '0) && (stat_err_cnt != '1)) stat_err_cnt <= stat_err_cnt + 32'd1;
      if (w_err > stat_max_err) stat_max_err <= w_err;
    end
  end
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Scoreboard bench for approx_add_pipe (WIDTH=16, K=4, STAGES=2). The driver pushes an expected
// {mode, sum} for each accepted beat. The monitor pops and compares every delivered result.
module tb_approx_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_sum;
  logic        out_mode;
`ifdef APPROX_ADD_STATS_EN
  logic [31:0] stat_beats;
  logic [31:0] stat_err_cnt;
  logic [15:0] stat_max_err;
  logic        stat_clr;
`endif

  int errors = 0;
  int checks = 0;

  logic [17:0] exp_q[$];
  logic        hold_chk = 1'b0;
  logic [18:0] hold_val;
  logic        saw_inrdy_low = 1'b0;
  logic        rand_done;

  always #5 clk = ~clk;

  approx_add_pipe #(
    .WIDTH(16),
    .APPROX_LSB(4),
    .STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_mode(in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum(out_sum),
    .out_mode(out_mode)
`ifdef APPROX_ADD_STATS_EN
    ,
    .stat_beats(stat_beats),
    .stat_err_cnt(stat_err_cnt),
    .stat_max_err(stat_max_err),
    .stat_clr(stat_clr)
`endif
  );

  // Reference: exact sum, or LOA = OR of the low nibble plus an exact upper sum with carry-in
  // a[3]&b[3]
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic m);
    logic [16:0] hi;
    if (!m) return {1'b0, a} + {1'b0, b};
    hi = {5'b0, a[15:4]} + {5'b0, b[15:4]} + {16'b0, a[3] & b[3]};
    return (hi << 4) | {13'b0, (a[3:0] | b[3:0])};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one beat, wait (bounded) for acceptance, record the expected result
  task automatic send_exp(input logic [15:0] a, input logic [15:0] b, input logic m,
                          input logic [16:0] e);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready) begin
      exp_q.push_back({m, e});
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic m);
    send_exp(a, b, m, model(a, b, m));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: compare delivered beats in order; a stalled output must not change
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_chk = 1'b0;
    end else begin
      if (!in_ready) saw_inrdy_low = 1'b1;
      if (hold_chk) check("stall_hold", {13'b0, out_valid, out_mode, out_sum}, {13'b0, hold_val});
      if (out_valid && out_ready) begin
        logic [17:0] e;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got sum %h with no beat outstanding", out_sum);
        end else begin
          e = exp_q.pop_front();
          check("out_sum", {15'b0, out_sum}, {15'b0, e[16:0]});
          check("out_mode", {31'b0, out_mode}, {31'b0, e[17]});
        end
      end
      hold_chk = out_valid && !out_ready;
      hold_val = {out_valid, out_mode, out_sum};
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
`ifdef APPROX_ADD_STATS_EN
    stat_clr  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_sum", {15'b0, out_sum}, 0);
    check("rst_out_mode", {31'b0, out_mode}, 0);
    check("rst_in_ready", {31'b0, in_ready}, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Exact carry-out with two-cycle latency
    out_ready = 1'b1;
    send_exp(16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    check("lat_cycle1_valid", {31'b0, out_valid}, 0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", {31'b0, out_valid}, 1);
    check("lat_cycle2_sum", {15'b0, out_sum}, 32'h10000);
    drain();

    // Approximate corner cases
    send_exp(16'h000F, 16'h0001, 1'b1, 17'h0000F);
    send_exp(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    drain();

    // Alternating modes on the same operands
    for (int i = 0; i < 6; i++) begin
      send_exp(16'h1234, 16'h0F0F, i[0], i[0] ? 17'h0213F : 17'h02143);
    end
    drain();

    // Back-pressure: out_ready low for cycles 3..6 while 8 beats stream in
    @(posedge clk);
    #1;
    saw_inrdy_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(16'($urandom), 16'($urandom), 1'($urandom));
        end
      end
      begin
        for (int c = 0; c < 30; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_in_ready_dropped", {31'b0, saw_inrdy_low}, 1);

    // Randomised traffic with random gaps and random back-pressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [15:0] a;
          logic [15:0] b;
          a = (i % 17 == 0) ? 16'hFFFF : 16'($urandom);
          b = (i % 13 == 0) ? 16'hFFFF : 16'($urandom);
          send(a, b, 1'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

`ifdef APPROX_ADD_STATS_EN
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    send_exp(16'h000F, 16'h0001, 1'b1, 17'h0000F);
    send_exp(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    send_exp(16'h1234, 16'h0F0F, 1'b0, 17'h02143);
    drain();
    @(posedge clk);
    #1;
    check("stat_beats", stat_beats, 3);
    check("stat_err_cnt", stat_err_cnt, 2);
    check("stat_max_err", {16'b0, stat_max_err}, 1);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check("stat_clr_beats", stat_beats, 0);
    check("stat_clr_err_cnt", stat_err_cnt, 0);
    check("stat_clr_max_err", {16'b0, stat_max_err}, 0);
`endif

    // Reset with a full, stalled pipe: everything in flight is discarded
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0);
    send(16'h3333, 16'h4444, 1'b1);
    #2;
    check("mid_full_valid", {31'b0, out_valid}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 0);
    check("mid_rst_sum", {15'b0, out_sum}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_stale", {31'b0, out_valid}, 0);
    send(16'hABCD, 16'h1357, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
